// File: rtl/wb_down_sequencer.sv
// wb_down_sequencer
// Splits one wide Wishbone slave access into narrow master beats, one per
// narrow word that has any byte lane selected. The narrow cycle is held for
// the whole access. Read data is gathered into a wide return word, and the
// wide side gets a single ack (or a single err) per access.
module wb_down_sequencer #(
    parameter int AW  = 32,
    parameter int SDW = 128,
    parameter int MDW = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [AW-1:0]      i_s_wb_adr,
    input  logic [SDW/8-1:0]   i_s_wb_sel,
    input  logic               i_s_wb_we,
    input  logic [SDW-1:0]     i_s_wb_dat,
    output logic [SDW-1:0]     o_s_wb_dat,
    input  logic               i_s_wb_cyc,
    input  logic               i_s_wb_stb,
    output logic               o_s_wb_ack,
    output logic               o_s_wb_err,
    output logic [AW-1:0]      o_m_wb_adr,
    output logic [MDW/8-1:0]   o_m_wb_sel,
    output logic               o_m_wb_we,
    output logic [MDW-1:0]     o_m_wb_dat,
    input  logic [MDW-1:0]     i_m_wb_dat,
    output logic               o_m_wb_cyc,
    output logic               o_m_wb_stb,
    input  logic               i_m_wb_ack,
    input  logic               i_m_wb_err
);
    localparam int SSW   = SDW / 8;
    localparam int MSW   = MDW / 8;
    localparam int NB    = SDW / MDW;
    localparam int SBITS = $clog2(SSW);   // byte-offset bits inside a wide word
    localparam int MBITS = $clog2(MSW);   // byte-offset bits inside a narrow word
    localparam int WB    = $clog2(NB);    // narrow word index bits

    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    // Result of searching the byte selects for the next narrow word to access.
    typedef struct packed {
        logic          hit;
        logic [WB-1:0] idx;
    } word_pick_t;

    // Lowest word index >= start whose byte-select group is nonzero.
    function automatic word_pick_t pick_word(input logic [SSW-1:0] sel, input int start);
        word_pick_t r;
        r = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (i >= start && sel[i*MSW +: MSW] != '0) begin
                r.hit = 1'b1;
                r.idx = WB'(i);
            end
        end
        return r;
    endfunction

    // Narrow beat address: wide-word base, word index, narrow byte offset zeroed.
    function automatic logic [AW-1:0] beat_adr(input logic [AW-SBITS-1:0] base,
                                               input logic [WB-1:0] w);
        return {base, {SBITS{1'b0}}} | (AW'(w) << MBITS);
    endfunction

    state_t              state;
    logic [AW-SBITS-1:0] adr_q;
    logic [SSW-1:0]      sel_q;
    logic                we_q;
    logic [SDW-1:0]      dat_q;
    logic [SDW-1:0]      buf_q;
    logic [WB-1:0]       w_q;

    word_pick_t          first_pick;
    word_pick_t          next_pick;
    logic [SDW-1:0]      buf_next;

    // The byte offset of the wide address never reaches the narrow bus.
    logic                unused_adr_bits;
    assign unused_adr_bits = ^i_s_wb_adr[SBITS-1:0];

    // Pick the first/next word to access and form the read buffer including this beat.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        first_pick = pick_word(i_s_wb_sel, 0);
        next_pick  = pick_word(sel_q, int'(w_q) + 1);
        buf_next   = buf_q;
        if (!we_q) begin
            buf_next[w_q*MDW +: MDW] = i_m_wb_dat;
        end
    end

    // Access sequencer: all outputs are registered in this single FSM block.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            // NOTE: the read buffer is a plain register (not a RAM), so it is reset with the rest of the state.
            state      <= IDLE;
            adr_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            dat_q      <= '0;
            buf_q      <= '0;
            w_q        <= '0;
            o_s_wb_dat <= '0;
            o_s_wb_ack <= 1'b0;
            o_s_wb_err <= 1'b0;
            o_m_wb_adr <= '0;
            o_m_wb_sel <= '0;
            o_m_wb_we  <= 1'b0;
            o_m_wb_dat <= '0;
            o_m_wb_cyc <= 1'b0;
            o_m_wb_stb <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_s_wb_ack <= 1'b0;
                    o_s_wb_err <= 1'b0;
                    o_s_wb_dat <= '0;
                    if (i_s_wb_cyc && i_s_wb_stb) begin
                        adr_q <= i_s_wb_adr[AW-1:SBITS];
                        sel_q <= i_s_wb_sel;
                        we_q  <= i_s_wb_we;
                        dat_q <= i_s_wb_dat;
                        buf_q <= '0;
                        if (first_pick.hit) begin
                            state      <= BEAT;
                            w_q        <= first_pick.idx;
                            o_m_wb_cyc <= 1'b1;
                            o_m_wb_stb <= 1'b1;
                            o_m_wb_we  <= i_s_wb_we;
                            o_m_wb_adr <= beat_adr(i_s_wb_adr[AW-1:SBITS], first_pick.idx);
                            o_m_wb_sel <= i_s_wb_sel[first_pick.idx*MSW +: MSW];
                            o_m_wb_dat <= i_s_wb_dat[first_pick.idx*MDW +: MDW];
                        end else begin
                            // Nothing selected: complete without touching the narrow bus.
                            state      <= DONE;
                            o_s_wb_ack <= 1'b1;
                        end
                    end
                end

                BEAT: begin
                    if (!i_s_wb_cyc) begin
                        // Wide master gave up: drop the narrow bus silently; a same-cycle ack is ignored.
                        state      <= IDLE;
                        o_m_wb_cyc <= 1'b0;
                        o_m_wb_stb <= 1'b0;
                    end else if (i_m_wb_err) begin
                        state      <= IDLE;
                        o_m_wb_cyc <= 1'b0;
                        o_m_wb_stb <= 1'b0;
                        o_s_wb_err <= 1'b1;
                    end else if (i_m_wb_ack) begin
                        buf_q <= buf_next;
                        if (next_pick.hit) begin
                            w_q        <= next_pick.idx;
                            o_m_wb_adr <= beat_adr(adr_q, next_pick.idx);
                            o_m_wb_sel <= sel_q[next_pick.idx*MSW +: MSW];
                            o_m_wb_dat <= dat_q[next_pick.idx*MDW +: MDW];
                        end else begin
                            state      <= DONE;
                            o_m_wb_cyc <= 1'b0;
                            o_m_wb_stb <= 1'b0;
                            o_s_wb_ack <= 1'b1;
                            o_s_wb_dat <= buf_next;
                        end
                    end
                end

                DONE: begin
                    // The ack set on entry lasts exactly this one cycle.
                    state      <= IDLE;
                    o_s_wb_ack <= 1'b0;
                    o_s_wb_dat <= '0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_down_sequencer.sv
// Bench for wb_down_sequencer: table of wide accesses with a narrow slave
// model, expected narrow beats and wide responses kept in scoreboard queues,
// plus hand-written reset and cycle-abandon sequences.
module tb_wb_down_sequencer;

    logic          i_clk;
    logic          i_rst;
    logic [31:0]   i_s_wb_adr;
    logic [15:0]   i_s_wb_sel;
    logic          i_s_wb_we;
    logic [127:0]  i_s_wb_dat;
    logic [127:0]  o_s_wb_dat;
    logic          i_s_wb_cyc;
    logic          i_s_wb_stb;
    logic          o_s_wb_ack;
    logic          o_s_wb_err;
    logic [31:0]   o_m_wb_adr;
    logic [3:0]    o_m_wb_sel;
    logic          o_m_wb_we;
    logic [31:0]   o_m_wb_dat;
    logic [31:0]   i_m_wb_dat;
    logic          o_m_wb_cyc;
    logic          o_m_wb_stb;
    logic          i_m_wb_ack;
    logic          i_m_wb_err;

    wb_down_sequencer #(.AW(32), .SDW(128), .MDW(32)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_s_wb_adr (i_s_wb_adr),
        .i_s_wb_sel (i_s_wb_sel),
        .i_s_wb_we  (i_s_wb_we),
        .i_s_wb_dat (i_s_wb_dat),
        .o_s_wb_dat (o_s_wb_dat),
        .i_s_wb_cyc (i_s_wb_cyc),
        .i_s_wb_stb (i_s_wb_stb),
        .o_s_wb_ack (o_s_wb_ack),
        .o_s_wb_err (o_s_wb_err),
        .o_m_wb_adr (o_m_wb_adr),
        .o_m_wb_sel (o_m_wb_sel),
        .o_m_wb_we  (o_m_wb_we),
        .o_m_wb_dat (o_m_wb_dat),
        .i_m_wb_dat (i_m_wb_dat),
        .o_m_wb_cyc (o_m_wb_cyc),
        .o_m_wb_stb (o_m_wb_stb),
        .i_m_wb_ack (i_m_wb_ack),
        .i_m_wb_err (i_m_wb_err)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
    } beat_t;

    typedef struct {
        logic        err;
        logic [127:0] dat;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0]  adr;
        logic [15:0]  sel;
        logic         we;
        logic [127:0] dat;
        logic [127:0] rdat;      // what the narrow slave returns, word by word
        int           lat;       // narrow slave wait cycles per beat
        int           err_beat;  // 1-based beat answered with err, 0 = none
        logic         exp_err;
        logic [127:0] exp_dat;
        int           exp_beats;
    } vec_t;

    beat_t        beat_q[$];
    resp_t        resp_q[$];
    vec_t         vecs[9];

    int           n_cmp = 0;
    int           n_bad = 0;
    int           total_beats = 0;
    int           slave_lat = 0;
    int           err_beat = 0;
    logic [127:0] cur_rdat = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Expected narrow beats for a wide access, truncated at max_beats.
    task automatic gen_beats(input vec_t v, input int max_beats);
        int n;
        n = 0;
        for (int w = 0; w < 4; w++) begin
            if (v.sel[w*4 +: 4] != 4'h0 && n < max_beats) begin
                beat_t b;
                b.adr = {v.adr[31:4], 4'h0} + 32'(w * 4);
                b.sel = v.sel[w*4 +: 4];
                b.we  = v.we;
                b.dat = v.we ? v.dat[w*32 +: 32] : 32'h0;
                beat_q.push_back(b);
                n++;
            end
        end
    endtask

    // Narrow slave model: waits slave_lat cycles per beat, then acks (or errs).
    initial begin
        int wait_cnt;
        int beat_num;
        wait_cnt   = 0;
        beat_num   = 0;
        i_m_wb_ack = 1'b0;
        i_m_wb_err = 1'b0;
        i_m_wb_dat = 32'hBAD0_BAD0;
        forever begin
            tick();
            i_m_wb_ack = 1'b0;
            i_m_wb_err = 1'b0;
            i_m_wb_dat = 32'hBAD0_BAD0;
            if (o_m_wb_cyc && o_m_wb_stb) begin
                if (wait_cnt >= slave_lat) begin
                    wait_cnt = 0;
                    beat_num++;
                    total_beats++;
                    if (beat_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL beat_extra: got adr %0h required no beat", o_m_wb_adr);
                    end else begin
                        beat_t e;
                        e = beat_q.pop_front();
                        check("beat", {o_m_wb_adr, o_m_wb_sel, o_m_wb_we, (o_m_wb_we ? o_m_wb_dat : 32'h0)},
                              {e.adr, e.sel, e.we, e.dat});
                    end
                    if (beat_num == err_beat) begin
                        i_m_wb_err = 1'b1;
                    end else begin
                        i_m_wb_ack = 1'b1;
                        i_m_wb_dat = cur_rdat[o_m_wb_adr[3:2]*32 +: 32];
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                beat_num = 0;
            end
        end
    end

    task automatic run_vec(input int id, input vec_t v);
        resp_t r;
        int    beats0;
        int    exp_lat;
        logic  done;
        logic  seen_cyc;
        logic  gap;
        cur_rdat  = v.rdat;
        slave_lat = v.lat;
        err_beat  = v.err_beat;
        gen_beats(v, (v.err_beat > 0) ? v.err_beat : 4);
        exp_lat = (v.exp_beats == 0) ? 1 : v.exp_beats * (v.lat + 1) + 1;
        r.err = v.exp_err;
        r.dat = v.exp_dat;
        r.lat = exp_lat;
        resp_q.push_back(r);
        beats0   = total_beats;
        done     = 1'b0;
        seen_cyc = 1'b0;
        gap      = 1'b0;

        i_s_wb_adr = v.adr;
        i_s_wb_sel = v.sel;
        i_s_wb_we  = v.we;
        i_s_wb_dat = v.dat;
        i_s_wb_cyc = 1'b1;
        i_s_wb_stb = 1'b1;

        for (int c = 1; c <= 64 && !done; c++) begin
            tick();
            if (o_m_wb_cyc) seen_cyc = 1'b1;
            if (o_s_wb_ack || o_s_wb_err) begin
                done = 1'b1;
                if (resp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL v%0d_resp_extra: got ack=%b err=%b required none", id, o_s_wb_ack, o_s_wb_err);
                end else begin
                    resp_t e;
                    e = resp_q.pop_front();
                    check($sformatf("v%0d_resp_kind", id), {o_s_wb_ack, o_s_wb_err}, {~e.err, e.err});
                    if (!e.err) check($sformatf("v%0d_rdata", id), o_s_wb_dat, e.dat);
                    check($sformatf("v%0d_latency", id), c, e.lat);
                end
            end else if (seen_cyc && !o_m_wb_cyc) begin
                gap = 1'b1;
            end
        end
        i_s_wb_cyc = 1'b0;
        i_s_wb_stb = 1'b0;

        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL v%0d_timeout: got no ack/err required a response", id);
        end
        resp_q.delete();
        check($sformatf("v%0d_cyc_used", id), seen_cyc, (v.exp_beats != 0));
        check($sformatf("v%0d_cyc_gap", id), gap, 1'b0);
        check($sformatf("v%0d_beat_count", id), total_beats - beats0, v.exp_beats);
        check($sformatf("v%0d_beats_left", id), beat_q.size(), 0);
        beat_q.delete();
        tick();
        check($sformatf("v%0d_post_idle", id), {o_s_wb_ack, o_s_wb_err, o_m_wb_cyc, o_m_wb_stb}, 4'b0);
    endtask

    function automatic logic [255:0] all_outs();
        return {o_s_wb_ack, o_s_wb_err, o_s_wb_dat, o_m_wb_adr, o_m_wb_sel,
                o_m_wb_we, o_m_wb_dat, o_m_wb_cyc, o_m_wb_stb};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   beats0;
        i_rst      = 1'b1;
        i_s_wb_adr = '0;
        i_s_wb_sel = '0;
        i_s_wb_we  = 1'b0;
        i_s_wb_dat = '0;
        i_s_wb_cyc = 1'b0;
        i_s_wb_stb = 1'b0;

        vecs[0] = '{adr:32'h100, sel:16'hFFFF, we:1'b1,
                    dat:128'h00000044_00000033_00000022_00000011, rdat:'0,
                    lat:1, err_beat:0, exp_err:1'b0, exp_dat:'0, exp_beats:4};
        vecs[1] = '{adr:32'h200, sel:16'h0F00, we:1'b0, dat:'0,
                    rdat:128'h00000000_DEADBEEF_00000000_00000000,
                    lat:1, err_beat:0, exp_err:1'b0,
                    exp_dat:128'h00000000_DEADBEEF_00000000_00000000, exp_beats:1};
        vecs[2] = '{adr:32'h300, sel:16'hF00F, we:1'b0, dat:'0,
                    rdat:128'h0000000B_55555555_66666666_0000000A,
                    lat:0, err_beat:0, exp_err:1'b0,
                    exp_dat:128'h0000000B_00000000_00000000_0000000A, exp_beats:2};
        vecs[3] = '{adr:32'h400, sel:16'hFFFF, we:1'b1,
                    dat:128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000, rdat:'0,
                    lat:1, err_beat:2, exp_err:1'b1, exp_dat:'0, exp_beats:2};
        vecs[4] = '{adr:32'h500, sel:16'h0000, we:1'b0, dat:'0,
                    rdat:{4{32'hFFFF_FFFF}},
                    lat:0, err_beat:0, exp_err:1'b0, exp_dat:'0, exp_beats:0};
        vecs[5] = '{adr:32'h1234_5678, sel:16'h1248, we:1'b0, dat:'0,
                    rdat:128'h13131313_24242424_35353535_46464646,
                    lat:0, err_beat:0, exp_err:1'b0,
                    exp_dat:128'h13131313_24242424_35353535_46464646, exp_beats:4};
        vecs[6] = '{adr:32'h600, sel:16'hF0F0, we:1'b1,
                    dat:128'h11112222_33334444_55556666_77778888, rdat:'0,
                    lat:2, err_beat:0, exp_err:1'b0, exp_dat:'0, exp_beats:2};
        vecs[7] = '{adr:32'h700, sel:16'h00F0, we:1'b0, dat:'0,
                    rdat:128'h1,
                    lat:0, err_beat:1, exp_err:1'b1, exp_dat:'0, exp_beats:1};
        vecs[8] = '{adr:32'hFFFF_FFF0, sel:16'hFFFF, we:1'b0, dat:'0,
                    rdat:128'h01234567_89ABCDEF_FEDCBA98_76543210,
                    lat:0, err_beat:0, exp_err:1'b0,
                    exp_dat:128'h01234567_89ABCDEF_FEDCBA98_76543210, exp_beats:4};

        repeat (3) tick();
        check("reset_state", all_outs(), '0);
        i_rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while the first beat is on the narrow bus.
        v = vecs[8];
        v.adr     = 32'h800;
        cur_rdat  = v.rdat;
        slave_lat = 2;
        err_beat  = 0;
        beats0    = total_beats;
        i_s_wb_adr = v.adr;
        i_s_wb_sel = v.sel;
        i_s_wb_we  = 1'b0;
        i_s_wb_dat = '0;
        i_s_wb_cyc = 1'b1;
        i_s_wb_stb = 1'b1;
        tick();
        check("rst_beat1_live", {o_m_wb_cyc, o_m_wb_stb, o_m_wb_adr}, {2'b11, 32'h800});
        i_rst = 1'b1;
        tick();
        check("rst_mid_access", all_outs(), '0);
        i_rst      = 1'b0;
        i_s_wb_cyc = 1'b0;
        i_s_wb_stb = 1'b0;
        tick();
        check("rst_no_resp", {o_s_wb_ack, o_s_wb_err, o_m_wb_cyc}, 3'b0);
        check("rst_no_beats", total_beats - beats0, 0);

        // Wide cycle dropped while the second beat is being acked.
        v.adr     = 32'h900;
        slave_lat = 1;
        beats0    = total_beats;
        gen_beats(v, 2);
        i_s_wb_adr = v.adr;
        i_s_wb_cyc = 1'b1;
        i_s_wb_stb = 1'b1;
        repeat (3) tick();
        check("drop_beat2_live", {o_m_wb_stb, o_m_wb_adr}, {1'b1, 32'h904});
        tick();
        i_s_wb_cyc = 1'b0;
        i_s_wb_stb = 1'b0;
        tick();
        check("drop_bus_released", {o_s_wb_ack, o_s_wb_err, o_m_wb_cyc, o_m_wb_stb}, 4'b0);
        repeat (2) begin
            tick();
            check("drop_stays_quiet", {o_s_wb_ack, o_s_wb_err, o_m_wb_cyc}, 3'b0);
        end
        check("drop_beat_count", total_beats - beats0, 2);
        check("drop_beats_left", beat_q.size(), 0);
        beat_q.delete();

        // Normal service resumes afterwards.
        run_vec(9, vecs[0]);
        run_vec(10, vecs[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
